instruction_fetch_unit: RTL

//  Producer side of the fetch->decode interface. Fetches 32-bit RISC-V words from instruction

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/instr_queue.sv | 59 +++++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch FSM states, NOP encoding and RV32I major opcodes shared with decode
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   // addi x0,x0,0
   localparam logic [31:0] FETCH_NOP = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - DEPTH-entry synchronous FIFO of {pc, instr} pairs; flush wins over push/pop
module instr_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [63:0]   push_data_i,
   input  logic          pop_i,
   output logic [63:0]   head_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_i && !pop_i)      count_d = count_q + 1'b1;
         else if (!push_i && pop_i) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: count gates every read
   always_ff @(posedge clock) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch FSM, PC and issue register feeding the decoder from instr_queue
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     available,
   output logic                     decodePulse,
   output logic [31:0]              instr,
   output logic [31:0]              instrPC,
   output logic                     memReq,
   output logic [31:0]              memAddr,
   input  logic                     memValid,
   input  logic [31:0]              memData,
   input  logic                     redirectValid,
   input  logic [31:0]              redirectPC,
   output logic [$clog2(DEPTH):0]   queueCount
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic          pulse_q, pulse_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   instr_pc_q, instr_pc_d;
   logic [63:0]   head;
   logic [CW-1:0] q_count;
   logic          push, pop, room;

   assign pop  = (q_count != '0) && available && !redirectValid;
   assign push = (state_q == S_WAIT) && memValid && !redirectValid;
   // a slot freed by this cycle's pop is usable by a request issued this cycle
   assign room = (q_count < DEPTH_C) || pop;

   instr_queue #(.DEPTH(DEPTH)) u_queue (
      .clock       (clock),
      .reset       (reset),
      .flush_i     (redirectValid),
      .push_i      (push),
      .push_data_i ({pc_q, memData}),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (q_count)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         S_IDLE: begin
            if (!redirectValid && room) begin
               state_d    = S_WAIT;
               mem_addr_d = pc_q;
            end
         end
         S_WAIT: begin
            if (redirectValid) begin
               state_d = memValid ? S_IDLE : S_DISCARD;
            end else if (memValid) begin
               state_d = S_IDLE;
               pc_d    = pc_q + 32'd4;
            end
         end
         S_DISCARD: begin
            if (memValid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (redirectValid) pc_d = redirectPC & ~32'h3;
   end

   always_comb begin
      pulse_d    = pop;
      instr_d    = pop ? head[31:0]  : instr_q;
      instr_pc_d = pop ? head[63:32] : instr_pc_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         mem_addr_q <= '0;
         pulse_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         pulse_q    <= pulse_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign memReq      = (state_q == S_WAIT);
   assign memAddr     = mem_addr_q;
   assign decodePulse = pulse_q;
   assign instr       = instr_q;
   assign instrPC     = instr_pc_q;
   assign queueCount  = q_count;

endmodule
